// File: rtl/nn_sched_pkg.sv
// Shared definitions for the epoch shuffle sequencer.
//   state_e      : sequencer FSM states
//   LFSR_TAPS    : Galois feedback mask for x^16+x^14+x^13+x^11+1
//   SEED_DEF     : LFSR reset value, also substituted for a zero seed
//   sample_mask  : smallest all-ones mask covering i (2^ceil(log2(i+1)) - 1)
package nn_sched_pkg;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] SEED_DEF  = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    SHUFFLE,
    STREAM
  } state_e;

  // Smear the highest set bit downwards to get an all-ones mask >= i.
  function automatic logic [15:0] sample_mask(input logic [15:0] i);
    logic [15:0] m;
    m = i;
    for (int unsigned s = 1; s < 16; s = s << 1) begin
      m = m | (m >> s);
    end
    return m;
  endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Right-shifting Galois LFSR.
//   clk, rst  : clock, asynchronous active-high reset (loads RESET_VAL)
//   step      : advance one position
//   load      : load load_val (has priority over step)
//   load_val  : value to load
//   q         : current LFSR state
module lfsr_galois #(
  parameter int unsigned     W         = 16,
  parameter logic [W-1:0]    TAPS      = '0,
  parameter logic [W-1:0]    RESET_VAL = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q
);

  logic [W-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = load_val;
    end else if (step) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RESET_VAL;
    end else begin
      state_q <= state_d;
    end
  end

  assign q = state_q;

endmodule

// File: rtl/epoch_shuffle_sequencer.sv
// Per-epoch training-sample scheduler: builds the identity table 0..N-1,
// Fisher-Yates shuffles it with an LFSR, then streams the permutation.
//   clk, rst            : clock, asynchronous active-high reset
//   cfg_count           : epoch size N, sampled on an accepted start
//   start               : start-epoch pulse (honoured in IDLE only)
//   seed_load/seed_value: reseed the LFSR in IDLE; zero seed means SEED_DEF
//   busy                : high outside IDLE
//   done                : 1-cycle pulse after the last index is accepted
//   err                 : 1-cycle pulse when a start carries an invalid N
//   idx_valid/idx_ready : index stream handshake
//   idx_data/idx_last   : permuted index, final-index marker
//   epoch_cnt           : completed epochs (wrapping)
module epoch_shuffle_sequencer #(
  parameter int unsigned        MAX_SAMPLES = 256,
  parameter int unsigned        IDX_W       = 8,
  parameter int unsigned        LFSR_W      = 16,
  parameter logic [LFSR_W-1:0]  SEED_DEF    = LFSR_W'(nn_sched_pkg::SEED_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W:0]    cfg_count,
  input  logic              start,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_value,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              idx_valid,
  input  logic              idx_ready,
  output logic [IDX_W-1:0]  idx_data,
  output logic              idx_last,
  output logic [15:0]       epoch_cnt
);

  import nn_sched_pkg::*;

  state_e            state_q, state_d;
  logic [IDX_W:0]    n_q, n_d;
  logic [IDX_W-1:0]  k_q, k_d;
  logic [IDX_W-1:0]  i_q, i_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [15:0]       epoch_q, epoch_d;
  logic [IDX_W-1:0]  tbl_q [MAX_SAMPLES];

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_load_val;
  logic              lfsr_load, lfsr_step;
  logic [15:0]       mask_w;
  logic [LFSR_W-1:0] draw_w;
  logic [IDX_W-1:0]  draw_r;
  logic              k_is_last;
  logic              init_we, swap_we;

  assign lfsr_load     = (state_q == IDLE) && seed_load;
  assign lfsr_load_val = (seed_value == '0) ? SEED_DEF : seed_value;
  assign lfsr_step     = (state_q == SHUFFLE);

  lfsr_galois #(
    .W         (LFSR_W),
    .TAPS      (LFSR_W'(LFSR_TAPS)),
    .RESET_VAL (SEED_DEF)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .step     (lfsr_step),
    .load     (lfsr_load),
    .load_val (lfsr_load_val),
    .q        (lfsr_q)
  );

  // Draw uses the pre-step LFSR value; mask only ever covers IDX_W bits.
  assign mask_w    = sample_mask(16'(i_q));
  assign draw_w    = lfsr_q & LFSR_W'(mask_w);
  assign draw_r    = draw_w[IDX_W-1:0];
  assign k_is_last = ({1'b0, k_q} == (n_q - (IDX_W+1)'(1)));

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    i_d     = i_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    epoch_d = epoch_q;
    init_we = 1'b0;
    swap_we = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if ((cfg_count != '0) && (cfg_count <= (IDX_W+1)'(MAX_SAMPLES))) begin
            n_d     = cfg_count;
            k_d     = '0;
            state_d = INIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      INIT: begin
        init_we = 1'b1;
        if (k_is_last) begin
          i_d     = k_q;
          k_d     = '0;
          state_d = (n_q == (IDX_W+1)'(1)) ? STREAM : SHUFFLE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      SHUFFLE: begin
        if (draw_w <= LFSR_W'(i_q)) begin
          swap_we = 1'b1;
          if (i_q == IDX_W'(1)) begin
            k_d     = '0;
            state_d = STREAM;
          end else begin
            i_d = i_q - 1'b1;
          end
        end
      end
      STREAM: begin
        if (idx_ready) begin
          if (k_is_last) begin
            done_d  = 1'b1;
            epoch_d = epoch_q + 1'b1;
            state_d = IDLE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      k_q     <= '0;
      i_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      epoch_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      i_q     <= i_d;
      done_q  <= done_d;
      err_q   <= err_d;
      epoch_q <= epoch_d;
    end
  end

  // Table has no reset; both swap writes land in one cycle (r==i writes the same value twice).
  always_ff @(posedge clk) begin
    if (init_we) begin
      tbl_q[k_q] <= k_q;
    end else if (swap_we) begin
      tbl_q[i_q]    <= tbl_q[draw_r];
      tbl_q[draw_r] <= tbl_q[i_q];
    end
  end

  assign busy      = (state_q != IDLE);
  assign idx_valid = (state_q == STREAM);
  assign idx_data  = idx_valid ? tbl_q[k_q] : '0;
  assign idx_last  = idx_valid && k_is_last;
  assign done      = done_q;
  assign err       = err_q;
  assign epoch_cnt = epoch_q;

endmodule

// File: tb/tb_epoch_shuffle_sequencer.sv
// Directed bench for epoch_shuffle_sequencer with an independent
// LFSR + Fisher-Yates reference model.
module tb_epoch_shuffle_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  cfg_count;
  logic        start;
  logic        seed_load;
  logic [15:0] seed_value;
  logic        busy, done, err, idx_valid, idx_ready, idx_last;
  logic [7:0]  idx_data;
  logic [15:0] epoch_cnt;

  always #5 clk = ~clk;

  epoch_shuffle_sequencer #(
    .MAX_SAMPLES (256),
    .IDX_W       (8),
    .LFSR_W      (16),
    .SEED_DEF    (16'hACE1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_count  (cfg_count),
    .start      (start),
    .seed_load  (seed_load),
    .seed_value (seed_value),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .idx_valid  (idx_valid),
    .idx_ready  (idx_ready),
    .idx_data   (idx_data),
    .idx_last   (idx_last),
    .epoch_cnt  (epoch_cnt)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_lfsr;
  int          m_perm [256];
  int          m_shuf;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic int ref_mask(input int i);
    int m = 0;
    while (m < i) m = (m << 1) | 1;
    return m;
  endfunction

  task automatic model_epoch(input int n);
    int i, r, t, guard;
    for (int k = 0; k < n; k++) m_perm[k] = k;
    m_shuf = 0;
    guard  = 0;
    i      = n - 1;
    while (i >= 1 && guard < 100000) begin
      r = int'(m_lfsr[7:0]) & ref_mask(i);
      m_lfsr = lfsr_next(m_lfsr);
      m_shuf++;
      guard++;
      if (r <= i) begin
        t = m_perm[i]; m_perm[i] = m_perm[r]; m_perm[r] = t;
        i--;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  logic [7:0] got [256];
  int         n_got;

  // Called just after a clock edge; returns 1 time unit after the start edge.
  task automatic start_epoch(input int n, input bit ld, input logic [15:0] sv);
    cfg_count  = 9'(n);
    start      = 1'b1;
    seed_load  = ld;
    seed_value = sv;
    @(posedge clk); #1;
    start     = 1'b0;
    seed_load = 1'b0;
  endtask

  task automatic run_stream(input int n, input bit rnd, input int exp_lat, input string tag);
    int         cyc = 0;
    int         stall_bad = 0, last_bad = 0;
    bit         fin = 0, seen = 0, stalled = 0;
    logic [7:0] pd = '0;
    logic       pl = 1'b0;
    n_got = 0;
    while (!fin && cyc < 6000) begin
      idx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (stalled && (!idx_valid || idx_data !== pd || idx_last !== pl)) stall_bad++;
      if (idx_valid) begin
        if (!seen) begin
          seen = 1;
          if (exp_lat >= 0) check_eq({tag, "_latency"}, cyc, exp_lat);
        end
        if (idx_ready) begin
          if (n_got < 256) got[n_got] = idx_data;
          if (idx_last !== (n_got == n - 1)) last_bad++;
          n_got++;
          stalled = 0;
          if (idx_last) fin = 1;
        end else begin
          stalled = 1;
          pd = idx_data;
          pl = idx_last;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    check_eq({tag, "_finished"}, fin, 1);
    check_eq({tag, "_xfers"}, n_got, n);
    check_eq({tag, "_last_flag_errs"}, last_bad, 0);
    if (rnd) check_eq({tag, "_stall_unstable"}, stall_bad, 0);
    check_eq({tag, "_done_valid_busy"}, {done, idx_valid, busy}, 3'b100);
    @(posedge clk); #1;
    check_eq({tag, "_done_single"}, done, 0);
  endtask

  task automatic check_perm(input int n, input string tag);
    int mism = 0, distinct = 0;
    bit seen [256];
    for (int k = 0; k < n; k++) begin
      if (int'(got[k]) != m_perm[k]) mism++;
      if (int'(got[k]) < n && !seen[got[k]]) begin
        seen[got[k]] = 1;
        distinct++;
      end
    end
    check_eq({tag, "_vs_model"}, mism, 0);
    check_eq({tag, "_is_perm"}, distinct, n);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check_eq(tag, {busy, done, err, idx_valid, idx_last, idx_data, epoch_cnt}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  logic [7:0] t1_got [8];
  logic [7:0] a_got  [16];
  int         t1_lat, diff, w;

  initial begin
    rst = 1'b1; start = 1'b0; seed_load = 1'b0; seed_value = '0;
    cfg_count = '0; idx_ready = 1'b0;
    #2;
    check_eq("reset_outs", {busy, done, err, idx_valid, idx_last, idx_data, epoch_cnt}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    m_lfsr = 16'hACE1;

    // 1: default seed, N=8, always ready
    model_epoch(8);
    t1_lat = 8 + m_shuf;
    start_epoch(8, 0, '0);
    run_stream(8, 0, t1_lat, "t1");
    check_perm(8, "t1");
    for (int k = 0; k < 8; k++) t1_got[k] = got[k];
    check_eq("t1_epoch_cnt", epoch_cnt, 1);

    // 2: N=1 skips shuffling entirely
    model_epoch(1);
    start_epoch(1, 0, '0);
    run_stream(1, 0, 1, "t2");
    check_eq("t2_data", got[0], 0);
    check_eq("t2_epoch_cnt", epoch_cnt, 2);

    // 3: rejected sizes
    start_epoch(0, 0, '0);
    check_eq("t3_err0_busy", {err, busy}, 2'b10);
    @(posedge clk); #1;
    check_eq("t3_err0_clear", err, 0);
    start_epoch(257, 0, '0);
    check_eq("t3_err257_busy", {err, busy}, 2'b10);
    @(posedge clk); #1;
    check_eq("t3_err257_clear", err, 0);
    check_eq("t3_epoch_cnt", epoch_cnt, 2);

    // 4: full-size epoch with random backpressure
    model_epoch(256);
    start_epoch(256, 0, '0);
    run_stream(256, 1, 256 + m_shuf, "t4");
    check_perm(256, "t4");
    check_eq("t4_epoch_cnt", epoch_cnt, 3);

    // 5: reset mid-SHUFFLE, reset mid-STREAM, then reproduce test 1
    start_epoch(8, 0, '0);
    repeat (10) @(posedge clk);
    #1;
    check_eq("t5_in_shuffle", {busy, idx_valid}, 2'b10);
    do_reset("t5_rst_shuffle");
    idx_ready = 1'b0;
    start_epoch(8, 0, '0);
    w = 0;
    while (!idx_valid && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    check_eq("t5_reach_stream", idx_valid, 1);
    idx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("t5_mid_stream", {busy, idx_valid}, 2'b11);
    do_reset("t5_rst_stream");
    start_epoch(8, 0, '0);
    run_stream(8, 0, t1_lat, "t5_rerun");
    diff = 0;
    for (int k = 0; k < 8; k++) if (got[k] !== t1_got[k]) diff++;
    check_eq("t5_rerun_matches_t1", diff, 0);
    check_eq("t5_epoch_cnt", epoch_cnt, 1);

    // 6a: zero seed loads the default seed
    seed_value = '0;
    seed_load  = 1'b1;
    @(posedge clk); #1;
    seed_load  = 1'b0;
    start_epoch(8, 0, '0);
    run_stream(8, 0, t1_lat, "t6_seed0");
    diff = 0;
    for (int k = 0; k < 8; k++) if (got[k] !== t1_got[k]) diff++;
    check_eq("t6_seed0_matches_t1", diff, 0);

    // 6b: seed_load with start, busy-time requests ignored, two N=16 epochs
    do_reset("t6_rst");
    m_lfsr = 16'h1234;
    model_epoch(16);
    start_epoch(16, 1, 16'h1234);
    cfg_count = 9'd5; start = 1'b1; seed_load = 1'b1; seed_value = 16'h5555;
    @(posedge clk); #1;
    start = 1'b0; seed_load = 1'b0;
    check_eq("t6_busy_ignore", {err, busy}, 2'b01);
    run_stream(16, 0, 16 + m_shuf - 1, "t6a");
    check_perm(16, "t6a");
    for (int k = 0; k < 16; k++) a_got[k] = got[k];
    model_epoch(16);
    start_epoch(16, 0, '0);
    run_stream(16, 0, 16 + m_shuf, "t6b");
    check_perm(16, "t6b");
    diff = 0;
    for (int k = 0; k < 16; k++) if (got[k] !== a_got[k]) diff++;
    check_eq("t6_epochs_differ", (diff != 0), 1);
    check_eq("t6_epoch_cnt", epoch_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
